// File: rtl/sfx_pkg.sv
// -----------------------------------------------------------------------------
// sfx_pkg
// Shared definitions for the sound-effect scheduler: scheduler states, effect
// ids, the per-effect divider and duration tables, and the duration scaling
// helper used when an effect is loaded.
// -----------------------------------------------------------------------------
package sfx_pkg;

   // Table size; the requester count of the scheduler is tied to this.
   localparam int SFX_NUM  = 4;
   localparam int SFX_ID_W = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      GAP  = 2'd2
   } sfx_state_e;

   localparam logic [1:0] SFX_EXPLODE = 2'd0;
   localparam logic [1:0] SFX_HIT     = 2'd1;
   localparam logic [1:0] SFX_BULLET  = 2'd2;
   localparam logic [1:0] SFX_PICKUP  = 2'd3;

   // Note divider per effect, indexed by effect id.
   localparam logic [31:0] SFX_DIV [SFX_NUM] = '{
      32'd90000, 32'd75000, 32'd120000, 32'd60000
   };

   // Effect length in clock cycles before scaling, indexed by effect id.
   localparam logic [31:0] SFX_DUR [SFX_NUM] = '{
      32'd10_000_000, 32'd2_500_000, 32'd5_000_000, 32'd1_250_000
   };

   // Scaled duration for an effect; never returns 0 so the play counter
   // always has at least one cycle to count down from.
   function automatic logic [31:0] sfx_dur_load(input logic [1:0] id,
                                                input int unsigned shift);
      logic [31:0] d_s;
      d_s = SFX_DUR[id] >> shift;
      if (d_s == 32'd0) begin
         d_s = 32'd1;
      end else begin
         d_s = d_s;
      end
      return d_s;
   endfunction

endpackage

// File: rtl/sfx_prio_enc.sv
// -----------------------------------------------------------------------------
// sfx_prio_enc
// Combinational lowest-index priority encoder.
// Ports:
//   req_vec : candidate vector, bit 0 has the highest priority
//   valid   : at least one candidate bit is set
//   idx     : index of the lowest set bit (0 when valid is low)
// -----------------------------------------------------------------------------
module sfx_prio_enc #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req_vec,
   output logic             valid,
   output logic [IDX_W-1:0] idx
);

   assign valid = |req_vec;

   // Scan from the top down so the lowest set index is the last one written.
   always_comb begin
      idx = {IDX_W{1'b0}};
      for (int i = N - 1; i >= 0; i--) begin
         idx = req_vec[i] ? IDX_W'(i) : idx;
      end
   end

endmodule

// File: rtl/sfx_arbiter.sv
// -----------------------------------------------------------------------------
// sfx_arbiter
// Shares the single square-wave tone generator between background music and
// four sound-effect requesters. Trigger pulses are latched into a pending set,
// the lowest-index candidate is granted, its divider is held for its scaled
// duration, then a silent gap is inserted before music returns.
//
// Optional feature macro: SFX_PREEMPT_EN
//   defined   : a higher-priority candidate replaces a playing effect at once
//               (no gap, the replaced effect is dropped)
//   undefined : effects always run to completion
//
// Ports:
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   req        : per-requester trigger pulses, bit 0 highest priority
//   bgm_div    : background-music divider
//   note_div   : registered divider to the tone generator, 0 = silence
//   sfx_active : high while an effect is playing
//   sfx_id     : playing or last-granted effect id
//   grant      : one-hot pulse on the cycle an effect starts
//   pending    : latched requests not yet served
// -----------------------------------------------------------------------------
module sfx_arbiter
   import sfx_pkg::*;
#(
   parameter int          NUM_REQ    = SFX_NUM,
   parameter int          DIV_W      = 22,
   parameter int          DUR_W      = 24,
   parameter int          GAP_CYCLES = 1000,
   parameter int unsigned DUR_SHIFT  = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic [DIV_W-1:0]   bgm_div,
   output logic [DIV_W-1:0]   note_div,
   output logic               sfx_active,
   output logic [1:0]         sfx_id,
   output logic [NUM_REQ-1:0] grant,
   output logic [NUM_REQ-1:0] pending
);

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_PLAY = PLAY;
   localparam logic [1:0] ST_GAP  = GAP;

   localparam int         GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
   localparam bit         GAP_EN   = (GAP_CYCLES != 0);

   logic [1:0]         state_r;
   logic [DUR_W-1:0]   cnt_r;
   logic [GAP_W-1:0]   gap_r;

   logic [NUM_REQ-1:0] cand_s;
   logic               enc_valid_s;
   logic [1:0]         enc_idx_s;
   logic [NUM_REQ-1:0] onehot_s;
   logic [DIV_W-1:0]   load_div_s;
   logic [DUR_W-1:0]   load_dur_s;
   logic               preempt_s;

   // A pulse arriving this cycle is already a candidate on this edge.
   assign cand_s = pending | req;

   sfx_prio_enc #(
      .N     (NUM_REQ),
      .IDX_W (2)
   ) u_prio_enc (
      .req_vec (cand_s),
      .valid   (enc_valid_s),
      .idx     (enc_idx_s)
   );

   assign onehot_s   = {{(NUM_REQ - 1){1'b0}}, 1'b1} << enc_idx_s;
   assign load_div_s = DIV_W'(SFX_DIV[enc_idx_s]);
   assign load_dur_s = DUR_W'(sfx_dur_load(enc_idx_s, DUR_SHIFT));

`ifdef SFX_PREEMPT_EN
   assign preempt_s = enc_valid_s && (enc_idx_s < sfx_id);
`else
   assign preempt_s = 1'b0;
`endif

   // Scheduler state machine; every output is registered here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         cnt_r      <= {DUR_W{1'b0}};
         gap_r      <= {GAP_W{1'b0}};
         note_div   <= {DIV_W{1'b0}};
         sfx_active <= 1'b0;
         sfx_id     <= 2'd0;
         grant      <= {NUM_REQ{1'b0}};
         pending    <= {NUM_REQ{1'b0}};
      end else begin
         grant   <= {NUM_REQ{1'b0}};
         pending <= cand_s;
         case (state_r)
            ST_IDLE: begin
               if (enc_valid_s) begin
                  state_r    <= ST_PLAY;
                  cnt_r      <= load_dur_s;
                  note_div   <= load_div_s;
                  sfx_active <= 1'b1;
                  sfx_id     <= enc_idx_s;
                  grant      <= onehot_s;
                  pending    <= cand_s & ~onehot_s;
               end else begin
                  note_div   <= bgm_div;
                  sfx_active <= 1'b0;
               end
            end
            ST_PLAY: begin
               if (preempt_s) begin
                  cnt_r      <= load_dur_s;
                  note_div   <= load_div_s;
                  sfx_id     <= enc_idx_s;
                  grant      <= onehot_s;
                  pending    <= cand_s & ~onehot_s;
               end else if (cnt_r <= DUR_W'(1)) begin
                  // Last play cycle: count parks at 0 instead of wrapping.
                  cnt_r      <= {DUR_W{1'b0}};
                  sfx_active <= 1'b0;
                  if (GAP_EN) begin
                     state_r  <= ST_GAP;
                     gap_r    <= GAP_LOAD;
                     note_div <= {DIV_W{1'b0}};
                  end else begin
                     state_r  <= ST_IDLE;
                     note_div <= bgm_div;
                  end
               end else begin
                  cnt_r <= cnt_r - DUR_W'(1);
               end
            end
            ST_GAP: begin
               if (gap_r <= GAP_W'(1)) begin
                  state_r  <= ST_IDLE;
                  gap_r    <= {GAP_W{1'b0}};
                  note_div <= bgm_div;
               end else begin
                  gap_r    <= gap_r - GAP_W'(1);
                  note_div <= {DIV_W{1'b0}};
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               note_div   <= {DIV_W{1'b0}};
               sfx_active <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sfx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sfx_arbiter
// Directed bench for sfx_arbiter with DUR_SHIFT=16 (explosion 152, hit 38,
// bullet 76, pickup 19 cycles), GAP_CYCLES=4 and bgm_div=191571.
// -----------------------------------------------------------------------------
module tb_sfx_arbiter;

   localparam logic [21:0] B   = 22'd191571;
   localparam logic [21:0] D_E = 22'd90000;
   localparam logic [21:0] D_H = 22'd75000;
   localparam logic [21:0] D_B = 22'd120000;
   localparam logic [21:0] D_P = 22'd60000;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [21:0] bgm_div;
   logic [21:0] note_div;
   logic        sfx_active;
   logic [1:0]  sfx_id;
   logic [3:0]  grant;
   logic [3:0]  pending;

   int n_vec = 0;
   int n_err = 0;

   sfx_arbiter #(
      .NUM_REQ    (4),
      .DIV_W      (22),
      .DUR_W      (24),
      .GAP_CYCLES (4),
      .DUR_SHIFT  (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .bgm_div    (bgm_div),
      .note_div   (note_div),
      .sfx_active (sfx_active),
      .sfx_id     (sfx_id),
      .grant      (grant),
      .pending    (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [3:0]  req;
      int          n;      // extra idle cycles after the driven cycle
      logic [21:0] note;
      logic        act;
      logic [1:0]  id;
      logic [3:0]  gnt;
      logic [3:0]  pend;
   } vec_t;

   vec_t tv[$];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string nm, input logic [21:0] en, input logic ea,
                          input logic [1:0] ei, input logic [3:0] eg, input logic [3:0] ep);
      n_vec++;
      if (note_div !== en) begin
         n_err++;
         $display("FAIL %s: note_div=%0d expected %0d", nm, note_div, en);
      end
      if (sfx_active !== ea) begin
         n_err++;
         $display("FAIL %s: sfx_active=%0b expected %0b", nm, sfx_active, ea);
      end
      if (sfx_id !== ei) begin
         n_err++;
         $display("FAIL %s: sfx_id=%0d expected %0d", nm, sfx_id, ei);
      end
      if (grant !== eg) begin
         n_err++;
         $display("FAIL %s: grant=%b expected %b", nm, grant, eg);
      end
      if (pending !== ep) begin
         n_err++;
         $display("FAIL %s: pending=%b expected %b", nm, pending, ep);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Count consecutive sampled cycles with note_div == val, bounded by lim.
   task automatic run_len(input logic [21:0] val, input int lim, output int len);
      len = 0;
      while (note_div === val && len < lim) begin
         len++;
         step();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int len;
      rst     = 1'b1;
      req     = 4'b0000;
      bgm_div = B;

      //           rst   req     n   note  act   id    gnt      pend
      // single bullet request
      tv.push_back('{1'b1, 4'b0000, 0, 22'd0, 1'b0, 2'd0, 4'b0000, 4'b0000});
      tv.push_back('{1'b0, 4'b0000, 0, B,     1'b0, 2'd0, 4'b0000, 4'b0000});
      tv.push_back('{1'b0, 4'b0100, 0, D_B,   1'b1, 2'd2, 4'b0100, 4'b0000});
      tv.push_back('{1'b0, 4'b0000, 74, D_B,  1'b1, 2'd2, 4'b0000, 4'b0000});
      tv.push_back('{1'b0, 4'b0000, 0, 22'd0, 1'b0, 2'd2, 4'b0000, 4'b0000});
      tv.push_back('{1'b0, 4'b0000, 2, 22'd0, 1'b0, 2'd2, 4'b0000, 4'b0000});
      tv.push_back('{1'b0, 4'b0000, 0, B,     1'b0, 2'd2, 4'b0000, 4'b0000});
      // simultaneous hit + pickup
      tv.push_back('{1'b0, 4'b1010, 0, D_H,   1'b1, 2'd1, 4'b0010, 4'b1000});
      tv.push_back('{1'b0, 4'b0000, 36, D_H,  1'b1, 2'd1, 4'b0000, 4'b1000});
      tv.push_back('{1'b0, 4'b0000, 0, 22'd0, 1'b0, 2'd1, 4'b0000, 4'b1000});
      tv.push_back('{1'b0, 4'b0000, 3, B,     1'b0, 2'd1, 4'b0000, 4'b1000});
      tv.push_back('{1'b0, 4'b0000, 0, D_P,   1'b1, 2'd3, 4'b1000, 4'b0000});
      tv.push_back('{1'b0, 4'b0000, 17, D_P,  1'b1, 2'd3, 4'b0000, 4'b0000});
      // request on the final play cycle latches and waits out the gap
      tv.push_back('{1'b0, 4'b0100, 0, 22'd0, 1'b0, 2'd3, 4'b0000, 4'b0100});
      tv.push_back('{1'b0, 4'b0000, 3, B,     1'b0, 2'd3, 4'b0000, 4'b0100});
      tv.push_back('{1'b0, 4'b0000, 0, D_B,   1'b1, 2'd2, 4'b0100, 4'b0000});
      tv.push_back('{1'b0, 4'b0000, 75, 22'd0, 1'b0, 2'd2, 4'b0000, 4'b0000});
      tv.push_back('{1'b0, 4'b0000, 3, B,     1'b0, 2'd2, 4'b0000, 4'b0000});
      // merged re-trigger: three pickup pulses during a bullet
      tv.push_back('{1'b0, 4'b0100, 0, D_B,   1'b1, 2'd2, 4'b0100, 4'b0000});
      tv.push_back('{1'b0, 4'b1000, 9, D_B,   1'b1, 2'd2, 4'b0000, 4'b1000});
      tv.push_back('{1'b0, 4'b1000, 9, D_B,   1'b1, 2'd2, 4'b0000, 4'b1000});
      tv.push_back('{1'b0, 4'b1000, 0, D_B,   1'b1, 2'd2, 4'b0000, 4'b1000});
      tv.push_back('{1'b0, 4'b0000, 53, D_B,  1'b1, 2'd2, 4'b0000, 4'b1000});
      tv.push_back('{1'b0, 4'b0000, 0, 22'd0, 1'b0, 2'd2, 4'b0000, 4'b1000});
      tv.push_back('{1'b0, 4'b0000, 3, B,     1'b0, 2'd2, 4'b0000, 4'b1000});
      tv.push_back('{1'b0, 4'b0000, 0, D_P,   1'b1, 2'd3, 4'b1000, 4'b0000});
      tv.push_back('{1'b0, 4'b0000, 18, 22'd0, 1'b0, 2'd3, 4'b0000, 4'b0000});
      tv.push_back('{1'b0, 4'b0000, 3, B,     1'b0, 2'd3, 4'b0000, 4'b0000});
      tv.push_back('{1'b0, 4'b0000, 5, B,     1'b0, 2'd3, 4'b0000, 4'b0000});
      // reset in the middle of an explosion, with requests during reset
      tv.push_back('{1'b0, 4'b0001, 0, D_E,   1'b1, 2'd0, 4'b0001, 4'b0000});
      tv.push_back('{1'b0, 4'b0000, 18, D_E,  1'b1, 2'd0, 4'b0000, 4'b0000});
      tv.push_back('{1'b1, 4'b0110, 0, 22'd0, 1'b0, 2'd0, 4'b0000, 4'b0000});
      tv.push_back('{1'b0, 4'b0000, 0, B,     1'b0, 2'd0, 4'b0000, 4'b0000});
      tv.push_back('{1'b0, 4'b0000, 3, B,     1'b0, 2'd0, 4'b0000, 4'b0000});

      for (int i = 0; i < tv.size(); i++) begin
         rst = tv[i].rst;
         req = tv[i].req;
         step();
         rst = 1'b0;
         req = 4'b0000;
         repeat (tv[i].n) step();
         chk_all($sformatf("vec%0d", i), tv[i].note, tv[i].act, tv[i].id,
                 tv[i].gnt, tv[i].pend);
      end

      // Explosion requested at cycle 10 of a bullet effect.
      req = 4'b0100;
      step();
      req = 4'b0000;
      chk_all("pre_bullet_grant", D_B, 1'b1, 2'd2, 4'b0100, 4'b0000);
      repeat (9) step();
      req = 4'b0001;
      step();
      req = 4'b0000;
`ifdef SFX_PREEMPT_EN
      chk_all("preempt_edge", D_E, 1'b1, 2'd0, 4'b0001, 4'b0000);
      run_len(D_E, 400, len);
      chk_int("preempt_explode_len", len, 152);
      run_len(22'd0, 50, len);
      chk_int("preempt_gap_len", len, 4);
      run_len(B, 20, len);
      chk_int("preempt_no_resume", len, 20);
      chk_all("preempt_end", B, 1'b0, 2'd0, 4'b0000, 4'b0000);
`else
      chk_all("nopre_edge", D_B, 1'b1, 2'd2, 4'b0000, 4'b0001);
      run_len(D_B, 400, len);
      chk_int("nopre_bullet_rest", len, 66);
      run_len(22'd0, 50, len);
      chk_int("nopre_gap_len", len, 4);
      run_len(B, 50, len);
      chk_int("nopre_idle_len", len, 1);
      chk_all("nopre_explode_grant", D_E, 1'b1, 2'd0, 4'b0001, 4'b0000);
      run_len(D_E, 400, len);
      chk_int("nopre_explode_len", len, 152);
      run_len(22'd0, 50, len);
      chk_int("nopre_gap2_len", len, 4);
      chk_all("nopre_end", B, 1'b0, 2'd0, 4'b0000, 4'b0000);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sfx_arbiter.md
# sfx_arbiter

Sound-effect scheduler that shares the single square-wave tone generator between background music and up to four sound-effect requesters (explosion, hit, bullet, pickup). It latches one-cycle trigger pulses, grants the highest-priority pending effect, and holds that effect's divider for its programmed duration. It then inserts a short silence gap and hands the generator back to background music. It sits between the game logic and the tone generator, replacing direct muxing of music and effect audio.

## Interface
- `NUM_REQ`, default 4: number of requesters; fixed to the package table size.
- `DIV_W`, default 22: width of note divider values.
- `DUR_W`, default 24: width of the duration counter.
- `GAP_CYCLES`, default 1000: silent cycles after each effect; 0 means no gap.
- `DUR_SHIFT`, default 0: right-shift applied to every table duration, used by simulation. A result of 0 is clamped to 1.
- `clk`, in, 1: system clock; everything is on the rising edge.
- `rst`, in, 1: reset; synchronous, active-high.
- `req`, in, NUM_REQ: per-requester trigger pulse; bit 0 has the highest priority.
- `bgm_div`, in, DIV_W: current background-music divider.
- `note_div`, out, DIV_W: registered divider to the tone generator; 0 means silence.
- `sfx_active`, out, 1: high while an effect is playing.
- `sfx_id`, out, 2: index of the playing or last-granted effect.
- `grant`, out, NUM_REQ: one-hot, one-cycle pulse on the cycle an effect starts.
- `pending`, out, NUM_REQ: latched, not-yet-served requests.

## Operation
- **State machine:** states are IDLE, PLAY, GAP.
- **Pending set:** `pending[i]` is set on any cycle with `req[i]=1`.
- **Pending clear:** `pending[i]` is cleared on the cycle requester i is granted.
- **Merging:** repeat pulses while a request is pending merge into the one bit.
- **Candidate set:** arbitration uses `pending | req`, so a pulse can be granted on the same edge it arrives.
- **IDLE:**
  - `note_div` follows `bgm_div`, delayed one register.
  - If any candidate exists, pick the lowest index k, then:
    - `note_div` = `SFX_DIV[k]`
    - duration counter = `max(SFX_DUR[k] >> DUR_SHIFT, 1)`
    - `grant[k]` pulses, `sfx_id` = k, `sfx_active` = 1
    - go to PLAY.
- **PLAY:**
  - The counter decrements each cycle.
  - On the cycle the counter equals 1, go to GAP, or to IDLE if `GAP_CYCLES` = 0.
  - The total time in PLAY is exactly the loaded count.
  - If the playing id is re-requested, it sets pending and replays after the gap.
- **GAP:**
  - `note_div` = 0 and `sfx_active` = 0 for `GAP_CYCLES` cycles, then go to IDLE.
  - Requests keep latching during GAP; none is granted until IDLE.
- **Width rules:**
  - Durations are unsigned.
  - The shift is applied before loading.
  - The counter never underflows.

## Timing
- **Reset values:** `note_div` = 0, `sfx_active` = 0, `sfx_id` = 0, `grant` = 0, `pending` = 0, state = IDLE.
- **Reset behaviour:** `req` in the same cycle as `rst` is ignored. Reset mid-PLAY or mid-GAP aborts immediately.
- **Grant latency:** with `req[k]` sampled high at edge t in IDLE, `note_div`, `grant`, and `sfx_active` are valid after edge t.
- **Return to music:** `note_div` returns to `bgm_div` one cycle after entering IDLE.
- **Simultaneous requests:** the lowest index wins and the others stay pending. They are served in index order, each preceded by a gap.
- **Request at the final PLAY cycle:** it latches, is not lost, and waits out the gap.

## Configuration
- **`SFX_PREEMPT_EN` defined:**
  - In PLAY, a candidate j with j < `sfx_id` preempts on that edge: it reloads the divider and duration and pulses `grant[j]`, with no gap.
  - The preempted effect is dropped, not resumed.
- **`SFX_PREEMPT_EN` undefined:** effects always run to completion, and higher-priority requests wait in pending.

## Structure
- **Package `sfx_pkg`:**
  - state enum `{IDLE, PLAY, GAP}`
  - `SFX_DIV` = {90000, 75000, 120000, 60000}
  - `SFX_DUR` = {10_000_000, 2_500_000, 5_000_000, 1_250_000}
  - id constants `SFX_EXPLODE` = 0, `SFX_HIT` = 1, `SFX_BULLET` = 2, `SFX_PICKUP` = 3.
- **Sub-module `sfx_prio_enc`:** combinational lowest-index priority encoder that outputs a valid flag and an index.

## Test plan
All scenarios use `DUR_SHIFT` = 16 (explosion 152, hit 38, bullet 76, pickup 19 cycles), `GAP_CYCLES` = 4, and `bgm_div` = 191571.
- **Single request:** reset, then a one-cycle `req[2]` → `grant` = 4'b0100, `note_div` = 120000 for exactly 76 cycles, `note_div` = 0 for 4 cycles, then `note_div` = 191571.
- **Simultaneous requests:** `req` = 4'b1010 on one cycle → hit plays 38 cycles, gap of 4, pickup plays 19 cycles, gap, then `pending` = 0.
- **Merged re-trigger:** three `req[3]` pulses during a playing bullet effect → pickup plays exactly once afterward.
- **Reset mid-effect:** `rst` at cycle 20 of an explosion → the next cycle shows `note_div` = 0 and `pending` = 0, and `req` during `rst` produces no grant.
- **Preemption (`SFX_PREEMPT_EN`):** `req[0]` at cycle 10 of a bullet effect → `grant` = 4'b0001 on that edge, `note_div` = 90000 for 152 cycles, and the bullet does not resume.
- **No preemption (macro undefined):** the same stimulus → the bullet completes 76 cycles, then the gap, then the explosion.
